// File: rtl/project_mux_ctrl.sv
// -----------------------------------------------------------------------------
// project_mux_ctrl
//   Wishbone-controlled I/O multiplexer that hands the user-area pads to one of
//   NUM_PROJ project macros. A project change is sequenced so that the pads
//   never see a half-switched state: isolate (optional), then hold the new
//   project in reset, then run. Unselected projects are always held in reset.
//
//   Optional feature macro: MUX_GUARD_EN
//     defined   -> an ISOLATE phase of GUARD_CYCLES precedes the RESET phase
//     undefined -> an accepted switch goes straight from RUN to RESET
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_*                     Wishbone slave (256-byte window at BASE_ADDR)
//   io_in / io_out / io_oeb   pad side (io_oeb active-low)
//   proj_io_in / proj_io_out  per-project pad buses, project i at [i*IO_W +: IO_W]
//   proj_reset                per-project active-high reset (registered)
//
// Register map (byte offsets)
//   0x00 ACTIVE  rw [7:0]   0x04 OEB_LO rw   0x08 OEB_HI rw   0x0C STATUS ro
// -----------------------------------------------------------------------------
module project_mux_ctrl #(
  parameter int          NUM_PROJ     = 8,
  parameter int          IO_W         = 38,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          GUARD_CYCLES = 16,
  parameter int          RST_CYCLES   = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [IO_W-1:0]          io_in,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  output logic [NUM_PROJ*IO_W-1:0] proj_io_in,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out,
  output logic [NUM_PROJ-1:0]      proj_reset
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2
  } state_t;

  localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef MUX_GUARD_EN
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);
`endif

  localparam logic [7:0] OFF_ACTIVE = 8'h00;
  localparam logic [7:0] OFF_OEB_LO = 8'h04;
  localparam logic [7:0] OFF_OEB_HI = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  state_t              state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic [7:0]          active_r, active_nx_s;
  logic [IO_W-1:0]     oeb_r;
  logic                sel_err_r, busy_err_r;
  logic                ack_r;
  logic [31:0]         dat_r;
  logic [NUM_PROJ-1:0] proj_reset_r, proj_reset_nx_s;

  logic        in_win_s, req_s, wr_s, rd_s;
  logic        act_wr_s, oeb_wr_s, status_rd_s;
  logic        sel_set_s, busy_set_s;
  logic [7:0]  off_s;
  logic [31:0] rdata_s;

  // Bus request decode; the ~ack term gives one ack per request and at most
  // one ack every second cycle for a master that keeps cyc/stb high.
  always_comb begin
    off_s       = wbs_adr_i[7:0];
    in_win_s    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    req_s       = wbs_cyc_i & wbs_stb_i & ~ack_r & in_win_s;
    wr_s        = req_s & wbs_we_i;
    rd_s        = req_s & ~wbs_we_i;
    act_wr_s    = wr_s & (off_s == OFF_ACTIVE) & wbs_sel_i[0];
    oeb_wr_s    = wr_s & (wbs_sel_i == 4'hF);
    status_rd_s = rd_s & (off_s == OFF_STATUS);
  end

  // Read data mux; unmapped in-window offsets read as zero.
  always_comb begin
    case (off_s)
      OFF_ACTIVE: rdata_s = {24'd0, active_r};
      OFF_OEB_LO: rdata_s = oeb_r[31:0];
      OFF_OEB_HI: rdata_s = 32'(oeb_r[IO_W-1:32]);
      OFF_STATUS: rdata_s = {14'd0, busy_err_r, sel_err_r, 6'd0, state_r, active_r};
      default:    rdata_s = 32'd0;
    endcase
  end

  // Switch sequencer next-state: each phase reloads the counter on entry and
  // leaves when the counter has counted down to one.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    active_nx_s = active_r;
    sel_set_s   = 1'b0;
    busy_set_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (act_wr_s) begin
          if (int'(wbs_dat_i[7:0]) < NUM_PROJ) begin
            active_nx_s = wbs_dat_i[7:0];
`ifdef MUX_GUARD_EN
            state_nx_s  = ST_ISOLATE;
            cnt_nx_s    = GUARD_LOAD;
`else
            state_nx_s  = ST_RESET;
            cnt_nx_s    = RST_LOAD;
`endif
          end else begin
            sel_set_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_ISOLATE: begin
        busy_set_s = act_wr_s;
        if (cnt_r <= CNT_ONE) begin
          state_nx_s = ST_RESET;
          cnt_nx_s   = RST_LOAD;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESET: begin
        busy_set_s = act_wr_s;
        if (cnt_r <= CNT_ONE) begin
          state_nx_s = ST_RUN;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Resets are derived from the next state so proj_reset[active] falls on the
  // same edge that the sequencer enters RUN.
  always_comb begin
    proj_reset_nx_s = '1;
    for (int i = 0; i < NUM_PROJ; i++) begin
      if ((state_nx_s == ST_RUN) && (active_nx_s == 8'(i))) begin
        proj_reset_nx_s[i] = 1'b0;
      end else begin
        proj_reset_nx_s[i] = 1'b1;
      end
    end
  end

  // Sequencer state, configuration registers, sticky flags and bus outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r      <= ST_RUN;
      cnt_r        <= '0;
      active_r     <= 8'd0;
      oeb_r        <= '1;
      sel_err_r    <= 1'b0;
      busy_err_r   <= 1'b0;
      ack_r        <= 1'b0;
      dat_r        <= 32'd0;
      proj_reset_r <= '1;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      active_r     <= active_nx_s;
      proj_reset_r <= proj_reset_nx_s;
      ack_r        <= req_s;
      if (rd_s) begin
        dat_r <= rdata_s;
      end else begin
        dat_r <= 32'd0;
      end
      // Set has priority over the clear caused by a STATUS read.
      sel_err_r  <= sel_set_s  | (sel_err_r  & ~status_rd_s);
      busy_err_r <= busy_set_s | (busy_err_r & ~status_rd_s);
      if (oeb_wr_s && (off_s == OFF_OEB_LO)) begin
        oeb_r[31:0] <= wbs_dat_i;
      end else if (oeb_wr_s && (off_s == OFF_OEB_HI)) begin
        oeb_r[IO_W-1:32] <= wbs_dat_i[IO_W-33:0];
      end else begin
        oeb_r <= oeb_r;
      end
    end
  end

  // Pad routing: only RUN drives the pads; RESET already feeds the new project.
  always_comb begin
    io_out     = '0;
    proj_io_in = '0;
    if (state_r == ST_RUN) begin
      io_oeb = oeb_r;
    end else begin
      io_oeb = '1;
    end
    for (int i = 0; i < NUM_PROJ; i++) begin
      if (active_r == 8'(i)) begin
        if (state_r == ST_RUN) begin
          io_out = proj_io_out[i*IO_W +: IO_W];
        end else begin
          io_out = '0;
        end
        if ((state_r == ST_RUN) || (state_r == ST_RESET)) begin
          proj_io_in[i*IO_W +: IO_W] = io_in;
        end else begin
          proj_io_in[i*IO_W +: IO_W] = '0;
        end
      end else begin
        proj_io_in[i*IO_W +: IO_W] = '0;
      end
    end
  end

  assign wbs_ack_o  = ack_r;
  assign wbs_dat_o  = dat_r;
  assign proj_reset = proj_reset_r;

endmodule

// File: tb/tb_project_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_project_mux_ctrl
//   Directed bench for project_mux_ctrl (default parameters). Bus transfers
//   push their expected read data into a scoreboard queue; a monitor pops and
//   compares on every ack. Pad/reset routing is checked directly per cycle.
// -----------------------------------------------------------------------------
module tb_project_mux_ctrl;

  localparam int NP    = 8;
  localparam int IO_W  = 38;
  localparam int R_CYC = 4;
`ifdef MUX_GUARD_EN
  localparam int G_EFF = 16;
`else
  localparam int G_EFF = 0;
`endif
  localparam logic [31:0] BASE = 32'h3000_0000;

  localparam logic [IO_W-1:0] SLICE0 = 38'h1C0DE0000;
  localparam logic [IO_W-1:0] SLICE3 = 38'h4C0DE0003;
  localparam logic [IO_W-1:0] SLICE5 = 38'h6C0DE0005;
  localparam logic [IO_W-1:0] PAD_IN = 38'h1512345678;
  localparam logic [IO_W-1:0] OEB_PROG = 38'h3FFFFF00FF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]            sel = 4'h0;
  logic [31:0]           adr = 32'd0, wdat = 32'd0;
  logic                  ack;
  logic [31:0]           rdat;
  logic [IO_W-1:0]       io_in, io_out, io_oeb;
  logic [NP*IO_W-1:0]    proj_io_in, proj_io_out;
  logic [NP-1:0]         proj_reset;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  project_mux_ctrl dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .proj_io_in  (proj_io_in),
    .proj_io_out (proj_io_out),
    .proj_reset  (proj_reset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack with data %h expected no ack", rdat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {32'd0, rdat}, {32'd0, e.data});
      end
    end
  end

  // One Wishbone transfer; acc returns the cycle count of the accepting edge.
  task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string name,
                         output int acc);
    bit got;
    exp_t e;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'd0, off}; wdat = d; sel = s;
    e.name = name; e.data = exp;
    exp_q.push_back(e);
    got = 1'b0;
    acc = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        acc = cyc_cnt;
      end
    end
    if (!got) begin
      check({name, "_ack_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input string name);
    int a;
    wb_xfer(1'b1, off, d, s, 32'd0, name, a);
  endtask

  task automatic wb_rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    int a;
    wb_xfer(1'b0, off, 32'd0, 4'hF, exp, name, a);
  endtask

  function automatic logic [1:0] st_at(input int k);
    if (k < G_EFF) return 2'd1;
    else if (k < G_EFF + R_CYC) return 2'd2;
    else return 2'd0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int a, n_ack, bad_dat, bad_pr, bad_io, bad_pin;
    logic [NP*IO_W-1:0] exp_pin;

    io_in = PAD_IN;
    for (int i = 0; i < NP; i++) begin
      proj_io_out[i*IO_W +: IO_W] = {6'(i + 1), 32'hC0DE_0000 | 32'(i)};
    end

    // ---- reset and defaults ----
    repeat (3) @(negedge clk);
    check("rst_proj_reset", {56'd0, proj_reset}, 64'hFF);
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_dat", {32'd0, rdat}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_proj_reset", {56'd0, proj_reset}, 64'hFE);
    check("rel_io_oeb", {26'd0, io_oeb}, {26'd0, {IO_W{1'b1}}});
    check("rel_io_out", {26'd0, io_out}, {26'd0, SLICE0});
    exp_pin = '0;
    exp_pin[0 +: IO_W] = PAD_IN;
    check("rel_proj_io_in", {63'd0, (proj_io_in === exp_pin)}, 64'd1);
    wb_rd(8'h00, 32'h0000_0000, "rd_active_reset");
    wb_rd(8'h0C, 32'h0000_0000, "rd_status_reset");

    // ---- byte selects on OEB ----
    wb_wr(8'h04, 32'h0000_0000, 4'h3, "wr_oeb_lo_partial");
    wb_rd(8'h04, 32'hFFFF_FFFF, "rd_oeb_lo_unchanged");
    wb_wr(8'h04, 32'hFFFF_00FF, 4'hF, "wr_oeb_lo_full");
    wb_rd(8'h04, 32'hFFFF_00FF, "rd_oeb_lo");
    wb_wr(8'h08, 32'h0000_0015, 4'hF, "wr_oeb_hi");
    wb_rd(8'h08, 32'h0000_0015, "rd_oeb_hi");
    wb_wr(8'h08, 32'hFFFF_FFFF, 4'hF, "wr_oeb_hi_all");
    wb_rd(8'h08, 32'h0000_003F, "rd_oeb_hi_masked");
    @(negedge clk);
    check("run_io_oeb", {26'd0, io_oeb}, {26'd0, OEB_PROG});

    // ---- held cyc/stb read of an unmapped offset ----
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h40; sel = 4'hF;
    exp_q.push_back('{"rd_unmapped_0x40", 32'd0});
    exp_q.push_back('{"rd_unmapped_0x40", 32'd0});
    n_ack = 0; bad_dat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
      else if (rdat !== 32'd0) bad_dat++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_ack_count", 64'(n_ack), 64'd2);
    check("idle_dat_zero", 64'(bad_dat), 64'd0);

    // ---- out-of-window access ----
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("out_of_window_no_ack", 64'(n_ack), 64'd0);

    // ---- sel_err ----
    wb_wr(8'h00, 32'h0000_0009, 4'hF, "wr_active_9");
    wb_rd(8'h0C, 32'h0001_0000, "rd_status_sel_err");
    wb_rd(8'h0C, 32'h0000_0000, "rd_status_cleared");
    wb_rd(8'h00, 32'h0000_0000, "rd_active_unchanged");

    // ---- switch to project 3 with cycle-exact phase checks ----
    wb_xfer(1'b1, 8'h00, 32'h0000_0003, 4'hF, 32'd0, "wr_active_3", a);
    bad_pr = 0; bad_io = 0; bad_pin = 0;
    for (int k = 1; k <= G_EFF + R_CYC + 1; k++) begin
      @(negedge clk);
      exp_pin = '0;
      if (k >= G_EFF) exp_pin[3*IO_W +: IO_W] = PAD_IN;
      if (proj_io_in !== exp_pin) bad_pin++;
      if (k < G_EFF + R_CYC) begin
        if (proj_reset !== 8'hFF) bad_pr++;
        if ((io_out !== '0) || (io_oeb !== {IO_W{1'b1}})) bad_io++;
      end
      if (k == G_EFF + R_CYC) begin
        check("sw3_proj_reset_run", {56'd0, proj_reset}, 64'hF7);
        check("sw3_io_out_run", {26'd0, io_out}, {26'd0, SLICE3});
        check("sw3_io_oeb_run", {26'd0, io_oeb}, {26'd0, OEB_PROG});
      end
    end
    check("sw3_proj_reset_held", 64'(bad_pr), 64'd0);
    check("sw3_pads_isolated", 64'(bad_io), 64'd0);
    check("sw3_proj_io_in", 64'(bad_pin), 64'd0);
    wb_rd(8'h00, 32'h0000_0003, "rd_active_3");
    wb_wr(8'h00, 32'h0000_0002, 4'hE, "wr_active_no_sel0");
    wb_rd(8'h00, 32'h0000_0003, "rd_active_still_3");

    // ---- busy_err: second ACTIVE write while switching to 5 ----
    wb_xfer(1'b1, 8'h00, 32'h0000_0005, 4'hF, 32'd0, "wr_active_5", a);
    wb_wr(8'h00, 32'h0000_0002, 4'hF, "wr_active_busy");
    wb_rd(8'h0C, {14'd0, 1'b1, 1'b0, 6'd0, st_at(5), 8'd5}, "rd_status_busy");
    wb_rd(8'h0C, {14'd0, 1'b0, 1'b0, 6'd0, st_at(8), 8'd5}, "rd_status_busy_clr");
    repeat (30) @(negedge clk);
    check("sw5_proj_reset", {56'd0, proj_reset}, 64'hDF);
    check("sw5_io_out", {26'd0, io_out}, {26'd0, SLICE5});
    check("sw5_proj_io_in", {26'd0, proj_io_in[5*IO_W +: IO_W]}, {26'd0, PAD_IN});
    wb_rd(8'h00, 32'h0000_0005, "rd_active_5");

    // ---- asynchronous reset in the middle of the RESET phase ----
    wb_xfer(1'b1, 8'h00, 32'h0000_0001, 4'hF, 32'd0, "wr_active_1", a);
    for (int w = 0; w < 100 && (cyc_cnt - a) < G_EFF + 1; w++) @(negedge clk);
    #1;
    check("pre_arst_io_out", {26'd0, io_out}, 64'd0);
    rst = 1'b1;
    #1;
    check("arst_proj_reset", {56'd0, proj_reset}, 64'hFF);
    check("arst_io_out", {26'd0, io_out}, {26'd0, SLICE0});
    check("arst_io_oeb", {26'd0, io_oeb}, {26'd0, {IO_W{1'b1}}});
    exp_pin = '0;
    exp_pin[0 +: IO_W] = PAD_IN;
    check("arst_proj_io_in", {63'd0, (proj_io_in === exp_pin)}, 64'd1);
    check("arst_ack", {63'd0, ack}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_proj_reset", {56'd0, proj_reset}, 64'hFE);
    wb_rd(8'h04, 32'hFFFF_FFFF, "rd_oeb_lo_after_arst");
    wb_rd(8'h0C, 32'h0000_0000, "rd_status_after_arst");
    wb_rd(8'h00, 32'h0000_0000, "rd_active_after_arst");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
